// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and Status/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_SYSCALL = 5'd8,
        EXC_BREAK   = 5'd9,
        EXC_TEQ     = 5'd13
    } exc_code_e;

    localparam int MODE_W       = 5;
    localparam int STATUS_IE    = 0;
    localparam int STATUS_IM_LO = 16;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_NOV    = 29;

    // The single event acting on the architectural registers in a cycle.
    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_ERET,
        EV_MTC0
    } cp0_event_e;

    // Cause as software sees it; ip[7] is the timer bit TI.
    function automatic logic [31:0] pack_cause(input logic [4:0] exc_code,
                                               input logic [7:0] ip,
                                               input logic       nov);
        logic [31:0] word;
        word = '0;
        word[CAUSE_EXC_LO +: 5] = exc_code;
        word[CAUSE_IP_LO  +: 8] = ip;
        word[CAUSE_NOV]         = nov;
        return word;
    endfunction

endpackage

// File: rtl/cp0_intc_if.sv
// Control-unit <-> CP0 bundle: instruction strobes and operands in, read data and targets out.
interface cp0_intc_if;

    logic        mfc0;
    logic        mtc0;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] exc_addr;
    logic        int_req;

    modport master (
        output mfc0, mtc0, pc, rd, wdata, exception, eret, cause,
        input  rdata, status, exc_addr, int_req
    );

    modport slave (
        input  mfc0, mtc0, pc, rd, wdata, exception, eret, cause,
        output rdata, status, exc_addr, int_req
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every CNT_DIV clocks; TI latches on a Count==Compare arrival.
module cp0_timer #(
    parameter int CNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        cmp_wr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DIV_W = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             count_upd;

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latch).
    always_comb begin
        count_d   = count_q;
        div_d     = div_q;
        count_upd = 1'b0;
        if (load) begin
            count_d   = wdata;
            div_d     = '0;
            count_upd = 1'b1;
        end else if (div_q == DIV_LAST) begin
            count_d   = count_q + 32'd1;
            div_d     = '0;
            count_upd = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        compare_d = cmp_wr ? wdata : compare_q;

        // A Compare write in the same cycle as the match keeps TI clear.
        ti_d = ti_q;
        if (cmp_wr)
            ti_d = 1'b0;
        else if (count_upd && (count_d == compare_q))
            ti_d = 1'b1;
    end

    // NOTE: clocked state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_intc.sv
// CP0 with nested-exception mode stack, external interrupt lines and Count/Compare timer.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ    = 6,
    parameter int          NEST_DEPTH = 3,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter logic [31:0] STATUS_RST = 32'h0000_001F,
    parameter int          CNT_DIV    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    cp0_intc_if.slave          bus
);

    localparam int         STK_W     = MODE_W * NEST_DEPTH;
    localparam logic [1:0] DEPTH_MAX = 2'(NEST_DEPTH);

    logic [31:0]        status_q, status_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic               nov_q, nov_d;
    logic [31:0]        epc_q, epc_d;
    logic [1:0]         depth_q, depth_d;
    logic [NUM_IRQ-1:0] irq_meta_q, irq_sync_q;

    cp0_event_e         ev;
    logic [STK_W-1:0]   stk, stk_push, stk_pop;
    logic [7:0]         ip;
    logic [31:0]        cause_word;
    logic [31:0]        count, compare;
    logic               ti;
    logic               count_load, compare_wr;

    // Exception beats eret beats mtc0; the losers are simply dropped.
    always_comb begin
        ev = EV_NONE;
        if (bus.exception)
            ev = EV_EXC;
        else if (bus.eret)
            ev = EV_ERET;
        else if (bus.mtc0)
            ev = EV_MTC0;
    end

    assign count_load = (ev == EV_MTC0) && (bus.rd == REG_COUNT);
    assign compare_wr = (ev == EV_MTC0) && (bus.rd == REG_COMPARE);

    cp0_timer #(
        .CNT_DIV (CNT_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (count_load),
        .cmp_wr  (compare_wr),
        .wdata   (bus.wdata),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );

    // Push drops the oldest mode off the top; pop refills the top slot with all-ones.
    always_comb begin
        stk      = status_q[STK_W-1:0];
        stk_push = stk << MODE_W;
        stk_pop  = (stk >> MODE_W) | ~({STK_W{1'b1}} >> MODE_W);
    end

    always_comb begin
        status_d   = status_q;
        exc_code_d = exc_code_q;
        nov_d      = nov_q;
        epc_d      = epc_q;
        depth_d    = depth_q;
        case (ev)
            EV_EXC: begin
                status_d[STK_W-1:0] = stk_push;
                exc_code_d          = bus.cause;
                epc_d               = bus.pc;
                if (depth_q == DEPTH_MAX)
                    nov_d = 1'b1;
                else
                    depth_d = depth_q + 2'd1;
            end
            EV_ERET: begin
                status_d[STK_W-1:0] = stk_pop;
                if (depth_q != 2'd0)
                    depth_d = depth_q - 2'd1;
            end
            EV_MTC0: begin
                case (bus.rd)
                    REG_STATUS: status_d = bus.wdata;
                    REG_CAUSE: begin
                        exc_code_d = bus.wdata[CAUSE_EXC_LO +: 5];
                        nov_d      = bus.wdata[CAUSE_NOV];
                    end
                    REG_EPC:    epc_d = bus.wdata;
                    default:    ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            exc_code_q <= '0;
            nov_q      <= 1'b0;
            epc_q      <= '0;
            depth_q    <= '0;
            irq_meta_q <= '0;
            irq_sync_q <= '0;
        end else begin
            status_q   <= status_d;
            exc_code_q <= exc_code_d;
            nov_q      <= nov_d;
            epc_q      <= epc_d;
            depth_q    <= depth_d;
            // Two-flop synchronizer for the asynchronous interrupt lines.
            irq_meta_q <= irq;
            irq_sync_q <= irq_meta_q;
        end
    end

    always_comb begin
        ip                = '0;
        ip[NUM_IRQ-1:0]   = irq_sync_q;
        ip[7]             = ti;
    end

    assign cause_word = pack_cause(exc_code_q, ip, nov_q);

    always_comb begin
        bus.rdata = '0;
        if (bus.mfc0) begin
            case (bus.rd)
                REG_COUNT:   bus.rdata = count;
                REG_COMPARE: bus.rdata = compare;
                REG_STATUS:  bus.rdata = status_q;
                REG_CAUSE:   bus.rdata = cause_word;
                REG_EPC:     bus.rdata = epc_q;
                default:     bus.rdata = '0;
            endcase
        end
    end

    assign bus.status   = status_q;
    assign bus.exc_addr = bus.eret ? epc_q : EXC_VECTOR;
    assign bus.int_req  = status_q[STATUS_IE] & (|(ip & status_q[STATUS_IM_LO +: 8]));

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: an arithmetic model of the CP0 registers is compared every cycle.
module tb_cp0_intc;
    import cp0_pkg::*;

    localparam int          NUM_IRQ    = 6;
    localparam int          NEST_DEPTH = 3;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;
    localparam logic [31:0] STATUS_RST = 32'h0000_001F;
    localparam int          CNT_DIV    = 2;

    logic               clk;
    logic               rst;
    logic [NUM_IRQ-1:0] irq;
    cp0_intc_if         bus ();

    int total = 0;
    int bad   = 0;

    cp0_intc #(
        .NUM_IRQ    (NUM_IRQ),
        .NEST_DEPTH (NEST_DEPTH),
        .EXC_VECTOR (EXC_VECTOR),
        .STATUS_RST (STATUS_RST),
        .CNT_DIV    (CNT_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .irq (irq),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Count is derived from the last load point: base + elapsed_cycles / CNT_DIV.
    logic [31:0]        m_status, m_epc, m_compare, m_base;
    logic [4:0]         m_exc;
    logic               m_nov, m_ti;
    logic [NUM_IRQ-1:0] m_irq1, m_ip;
    int                 m_depth, m_cyc, m_restart;

    function automatic logic [31:0] count_at(input int c);
        return m_base + 32'((c - m_restart) / CNT_DIV);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_exc) << 2) | (32'(m_ip) << 8) | (32'(m_ti) << 15) | (32'(m_nov) << 29);
    endfunction

    function automatic logic m_int_req();
        logic [7:0] ip8;
        ip8 = {m_ti, 1'b0, m_ip};
        return m_status[0] && ((ip8 & m_status[23:16]) != 8'd0);
    endfunction

    function automatic logic [31:0] m_rdata();
        if (!bus.mfc0) return 32'd0;
        case (bus.rd)
            5'd9:    return count_at(m_cyc);
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] old_c, new_c;
        logic        ex, er, wr, ld, cw, becomes;
        int          stk;
        ex = bus.exception;
        er = bus.eret && !ex;
        wr = bus.mtc0 && !ex && !bus.eret;
        ld = wr && (bus.rd == 5'd9);
        cw = wr && (bus.rd == 5'd11);
        old_c = count_at(m_cyc);
        new_c = ld ? bus.wdata : count_at(m_cyc + 1);
        if (ld) begin
            m_base    <= bus.wdata;
            m_restart <= m_cyc + 1;
        end
        becomes = (ld || (new_c != old_c)) && (new_c == m_compare);
        if (cw) begin
            m_compare <= bus.wdata;
            m_ti      <= 1'b0;
        end else if (becomes) begin
            m_ti <= 1'b1;
        end
        m_cyc  <= m_cyc + 1;
        m_ip   <= m_irq1;
        m_irq1 <= irq;
        stk = int'(m_status[14:0]);
        if (ex) begin
            m_status[14:0] <= 15'((stk * 32) % 32768);
            m_exc          <= bus.cause;
            m_epc          <= bus.pc;
            if (m_depth == NEST_DEPTH) m_nov <= 1'b1;
            else                       m_depth <= m_depth + 1;
        end else if (er) begin
            m_status[14:0] <= 15'(stk / 32 + 31 * 1024);
            if (m_depth > 0) m_depth <= m_depth - 1;
        end else if (wr) begin
            case (bus.rd)
                5'd12: m_status <= bus.wdata;
                5'd13: begin
                    m_exc <= bus.wdata[6:2];
                    m_nov <= bus.wdata[29];
                end
                5'd14: m_epc <= bus.wdata;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_status  <= STATUS_RST;
            m_epc     <= '0;
            m_compare <= '0;
            m_base    <= '0;
            m_exc     <= '0;
            m_nov     <= 1'b0;
            m_ti      <= 1'b0;
            m_irq1    <= '0;
            m_ip      <= '0;
            m_depth   <= 0;
            m_cyc     <= 0;
            m_restart <= 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("status", bus.status, m_status);
            check("int_req", 32'(bus.int_req), 32'(m_int_req()));
            check("exc_addr", bus.exc_addr, bus.eret ? m_epc : EXC_VECTOR);
            check("rdata", bus.rdata, m_rdata());
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.mfc0      = 1'b0;
        bus.mtc0      = 1'b0;
        bus.exception = 1'b0;
        bus.eret      = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.mtc0 = 1'b1; bus.rd = r; bus.wdata = d;
        cyc(); idle();
    endtask

    task automatic do_exc(input exc_code_e c, input logic [31:0] p);
        bus.exception = 1'b1; bus.cause = c; bus.pc = p;
        cyc(); idle();
    endtask

    task automatic do_eret();
        bus.eret = 1'b1;
        cyc(); idle();
    endtask

    task automatic rd_reg(input logic [4:0] r, output logic [31:0] v);
        bus.mfc0 = 1'b1; bus.rd = r;
        @(negedge clk);
        v = bus.rdata;
        cyc(); idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        rst = 1'b1; irq = '0; idle();
        bus.rd = '0; bus.pc = '0; bus.wdata = '0; bus.cause = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_status", bus.status, 32'h0000_001F);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_exc_addr", bus.exc_addr, 32'h0040_0004);
        check("rst_int_req", 32'(bus.int_req), 32'h0);
        cyc(); rst = 1'b0;

        // single exception and return
        do_exc(EXC_SYSCALL, 32'h0040_0020);
        @(negedge clk);
        check("exc_stack", 32'(bus.status[14:0]), 32'h03E0);
        cyc();
        rd_reg(REG_CAUSE, v); check("exc_cause", v, 32'h0000_0020);
        rd_reg(REG_EPC, v);   check("exc_epc", v, 32'h0040_0020);
        bus.eret = 1'b1;
        @(negedge clk);
        check("eret_addr", bus.exc_addr, 32'h0040_0020);
        cyc(); idle();
        @(negedge clk);
        check("eret_mode", 32'(bus.status[4:0]), 32'h1F);
        cyc();

        // nest overflow then unwind past empty
        do_exc(EXC_BREAK,   32'h0040_0040);
        do_exc(EXC_TEQ,     32'h0040_0044);
        do_exc(EXC_INT,     32'h0040_0048);
        do_exc(EXC_SYSCALL, 32'h0040_004C);
        check("model_depth_sat", 32'(m_depth), 32'd3);
        rd_reg(REG_CAUSE, v); check("nov_cause", v, 32'h2000_0020);
        rd_reg(REG_EPC, v);   check("nov_epc", v, 32'h0040_004C);
        repeat (4) do_eret();
        @(negedge clk);
        check("unwind_status", bus.status, 32'h0000_7FFF);
        check("model_depth_zero", 32'(m_depth), 32'd0);
        cyc();

        // Cause write touches only ExcCode/NOV; unknown index ignored
        do_mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        rd_reg(REG_CAUSE, v); check("cause_mask", v, 32'h2000_007C);
        do_mtc0(REG_CAUSE, 32'h0);
        do_mtc0(5'd5, 32'hDEAD_BEEF);
        rd_reg(5'd5, v); check("unmapped_read", v, 32'h0);

        // timer: TI on the 20th edge after Count=0 with Compare=10
        do_mtc0(REG_COUNT, 32'd0);
        do_mtc0(REG_COMPARE, 32'd10);
        do_mtc0(REG_STATUS, 32'h0080_0001);
        repeat (17) cyc();
        @(negedge clk); check("ti_edge19", 32'(bus.int_req), 32'h0);
        cyc();
        @(negedge clk); check("ti_edge20", 32'(bus.int_req), 32'h1);
        cyc();
        rd_reg(REG_CAUSE, v); check("ti_cause15", 32'(v[15]), 32'h1);
        do_mtc0(REG_COMPARE, 32'd10);
        @(negedge clk); check("ti_cleared", 32'(bus.int_req), 32'h0);
        cyc();

        // Compare write on the matching edge: clear wins
        do_mtc0(REG_COUNT, 32'd0);
        repeat (19) cyc();
        do_mtc0(REG_COMPARE, 32'd10);
        @(negedge clk); check("ti_clear_wins", 32'(bus.int_req), 32'h0);
        cyc();
        rd_reg(REG_COUNT, v); check("count_at_match", v, 32'd10);

        // external interrupt through the synchronizer
        do_mtc0(REG_STATUS, 32'h0004_0001);
        irq = 6'b00_0100;
        @(negedge clk); check("irq_edge0", 32'(bus.int_req), 32'h0);
        cyc();
        @(negedge clk); check("irq_edge1", 32'(bus.int_req), 32'h0);
        cyc();
        @(negedge clk); check("irq_edge2", 32'(bus.int_req), 32'h1);
        cyc();
        rd_reg(REG_CAUSE, v); check("irq_cause10", 32'(v[10]), 32'h1);
        do_mtc0(REG_STATUS, 32'h0004_0000);
        @(negedge clk); check("irq_ie_off", 32'(bus.int_req), 32'h0);
        cyc();
        irq = '0;

        // exception beats a same-cycle mtc0
        bus.mtc0 = 1'b1; bus.rd = REG_STATUS; bus.wdata = 32'h0;
        bus.exception = 1'b1; bus.cause = EXC_BREAK; bus.pc = 32'h0040_0100;
        cyc(); idle();
        @(negedge clk); check("exc_over_mtc0", bus.status, 32'h0004_0000);
        cyc();
        rd_reg(REG_EPC, v); check("exc_over_mtc0_epc", v, 32'h0040_0100);
        do_eret();

        // Count wrap
        do_mtc0(REG_COUNT, 32'hFFFF_FFFF);
        rd_reg(REG_COUNT, v); check("count_load", v, 32'hFFFF_FFFF);
        cyc();
        rd_reg(REG_COUNT, v); check("count_wrap", v, 32'h0);

        repeat (4) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
